ps2_keyboard_rx: RTL and testbench

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_glitch_filter.sv | 52 +++++
 rtl/ps2_keyboard_rx.sv | 195 +++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] PS2_KEY_LEFT   = 8'h6B;
    localparam logic [7:0] PS2_KEY_RIGHT  = 8'h74;
    localparam logic [7:0] PS2_KEY_DOWN   = 8'h72;
    localparam logic [7:0] PS2_KEY_ROTATE = 8'h75;

endpackage

// File: rtl/ps2_glitch_filter.sv
// Two-flop synchronizers for PS/2 clock and data, plus a run-length glitch
// filter on the clock that yields a filtered level and a falling-edge strobe.
module ps2_glitch_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_filt_o,
    output logic fall_o,
    output logic dat_sync_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fall_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            fall_q     <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= clk_sync_q[1];
                fall_q <= filt_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign clk_filt_o = filt_q;
    assign fall_o     = fall_q;
    assign dat_sync_o = dat_sync_q[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix tracking and frame timeout.
// Optional arrow-key level map is built when PS2_KEYMAP_EN is defined.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       iCLK_50M,
    input  logic       iRST_N,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [7:0] oScan_Code,
    output logic       oScan_Valid,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oParity_Err,
    output logic       oKey_Left,
    output logic       oKey_Right,
    output logic       oKey_Down,
    output logic       oKey_Rotate
);

    // state     | meaning
    // ST_IDLE   | waiting for a start bit (data=0 on a strobe)
    // ST_DATA   | shifting in 8 data bits, LSB first
    // ST_PARITY | capturing the parity bit
    // ST_STOP   | checking stop bit and odd parity, then deliver or drop

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic strobe;
    logic dat_s;
    logic ps2_clk_filt_unused;

    ps2_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk_i      (iCLK_50M),
        .rst_n_i    (iRST_N),
        .ps2_clk_i  (iPS2_CLK),
        .ps2_dat_i  (iPS2_DAT),
        .clk_filt_o (ps2_clk_filt_unused),
        .fall_o     (strobe),
        .dat_sync_o (dat_s)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          brk_out_q, brk_out_d;
    logic          ext_out_q, ext_out_d;
    logic          perr_q, perr_d;
`ifdef PS2_KEYMAP_EN
    logic [3:0]    keys_q, keys_d;
`endif

    always_ff @(posedge iCLK_50M) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            tmo_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            brk_out_q <= 1'b0;
            ext_out_q <= 1'b0;
            perr_q    <= 1'b0;
`ifdef PS2_KEYMAP_EN
            keys_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            tmo_q     <= tmo_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            brk_out_q <= brk_out_d;
            ext_out_q <= ext_out_d;
            perr_q    <= perr_d;
`ifdef PS2_KEYMAP_EN
            keys_q    <= keys_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        brk_out_d = brk_out_q;
        ext_out_d = ext_out_q;
        perr_d    = 1'b0;
`ifdef PS2_KEYMAP_EN
        keys_d    = keys_q;
`endif
        // Saturate while idle so the counter never wraps into a false timeout.
        if (strobe)                tmo_d = '0;
        else if (tmo_q == TMO_LAST) tmo_d = tmo_q;
        else                       tmo_d = tmo_q + 1'b1;

        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_s && (^{shift_q, par_q})) begin
                        if (shift_q == PS2_PREFIX_BRK) begin
                            brk_d = 1'b1;
                        end else if (shift_q == PS2_PREFIX_EXT) begin
                            ext_d = 1'b1;
                        end else begin
                            valid_d   = 1'b1;
                            code_d    = shift_q;
                            brk_out_d = brk_q;
                            ext_out_d = ext_q;
                            brk_d     = 1'b0;
                            ext_d     = 1'b0;
`ifdef PS2_KEYMAP_EN
                            if (ext_q) begin
                                case (shift_q)
                                    PS2_KEY_LEFT:   keys_d[0] = !brk_q;
                                    PS2_KEY_RIGHT:  keys_d[1] = !brk_q;
                                    PS2_KEY_DOWN:   keys_d[2] = !brk_q;
                                    PS2_KEY_ROTATE: keys_d[3] = !brk_q;
                                    default:        keys_d    = keys_q;
                                endcase
                            end
`endif
                        end
                    end else begin
                        perr_d = 1'b1;
                        brk_d  = 1'b0;
                        ext_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
        end
    end

    assign oScan_Code  = code_q;
    assign oScan_Valid = valid_q;
    assign oBreak      = brk_out_q;
    assign oExtended   = ext_out_q;
    assign oParity_Err = perr_q;

`ifdef PS2_KEYMAP_EN
    assign oKey_Left   = keys_q[0];
    assign oKey_Right  = keys_q[1];
    assign oKey_Down   = keys_q[2];
    assign oKey_Rotate = keys_q[3];
`else
    assign oKey_Left   = 1'b0;
    assign oKey_Right  = 1'b0;
    assign oKey_Down   = 1'b0;
    assign oKey_Rotate = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed frames plus randomized scan-code traffic
// checked against a frame-level model of prefix flags, errors and key levels.
module tb_ps2_keyboard_rx;

    localparam int FLT  = 8;
    localparam int TMO  = 300;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, brk, ext, perr;
    logic       key_l, key_r, key_d, key_rot;

    always #10 clk = ~clk;

    ps2_keyboard_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .iCLK_50M    (clk),
        .iRST_N      (rst_n),
        .iPS2_CLK    (ps2_clk),
        .iPS2_DAT    (ps2_dat),
        .oScan_Code  (scan_code),
        .oScan_Valid (scan_valid),
        .oBreak      (brk),
        .oExtended   (ext),
        .oParity_Err (perr),
        .oKey_Left   (key_l),
        .oKey_Right  (key_r),
        .oKey_Down   (key_d),
        .oKey_Rotate (key_rot)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    ev_t  last_exp = '0;
    int   perr_obs = 0;
    int   perr_exp = 0;
    int   checks = 0;
    int   errors = 0;
    logic m_brk = 1'b0;
    logic m_ext = 1'b0;
    logic [3:0] m_keys = 4'b0;

    always @(negedge clk) begin
        if (scan_valid) obs_q.push_back('{scan_code, brk, ext});
        if (perr) perr_obs++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(FLT - 1);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 10 - (FLT - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        if (glitch) begin
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(FLT - 1);
            ps2_clk = 1'b0;
            wait_cyc(HALF - 20 - (FLT - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic p;
        p = (~^b) ^ bad_par;
        clk_bit(1'b0, glitch);
        for (int i = 0; i < nbits; i++) clk_bit(b[i], glitch);
        if (nbits == 8) begin
            clk_bit(p, glitch);
            clk_bit(!bad_stop, glitch);
        end
        ps2_dat = 1'b1;
        wait_cyc(HALF);
    endtask

    // Frame-level model: what a keyboard byte means to the game logic.
    task automatic model_frame(input logic [7:0] b, input bit good, input bit complete);
        if (!complete || !good) begin
            if (complete) perr_exp++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            last_exp = '{b, m_brk, m_ext};
            exp_q.push_back(last_exp);
`ifdef PS2_KEYMAP_EN
            if (m_ext) begin
                if (b == 8'h6B) m_keys[0] = !m_brk;
                if (b == 8'h74) m_keys[1] = !m_brk;
                if (b == 8'h72) m_keys[2] = !m_brk;
                if (b == 8'h75) m_keys[3] = !m_brk;
            end
`endif
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic verify(input string tag);
        ev_t o, e;
        check({tag, ".nvalid"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, ".event"}, 32'(o), 32'(e));
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, ".perr"}, 32'(perr_obs), 32'(perr_exp));
        check({tag, ".held"}, 32'({scan_code, brk, ext}), 32'(last_exp));
        check({tag, ".keys"}, 32'({key_rot, key_d, key_r, key_l}), 32'(m_keys));
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit glitch);
        send_frame(b, bad_par, bad_stop, 8, glitch);
        model_frame(b, !(bad_par || bad_stop), 1'b1);
        verify(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({scan_code, scan_valid, brk, ext, perr, key_l, key_r, key_d, key_rot}), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] arrows [4];
        int r;
        arrows[0] = 8'h6B; arrows[1] = 8'h74; arrows[2] = 8'h72; arrows[3] = 8'h75;

        wait_cyc(5);
        check_all_zero("reset.during");
        rst_n = 1'b1;
        wait_cyc(5);
        check_all_zero("reset.after");

        do_frame("clean_1c", 8'h1C, 0, 0, 0);

        do_frame("ext_e0_a", 8'hE0, 0, 0, 0);
        do_frame("left_make", 8'h6B, 0, 0, 0);
        do_frame("ext_e0_b", 8'hE0, 0, 0, 0);
        do_frame("brk_f0", 8'hF0, 0, 0, 0);
        do_frame("left_break", 8'h6B, 0, 0, 0);

        do_frame("brk_before_perr", 8'hF0, 0, 0, 0);
        do_frame("bad_parity_29", 8'h29, 1, 0, 0);
        do_frame("good_29", 8'h29, 0, 0, 0);

        do_frame("brk_before_stop", 8'hF0, 0, 0, 0);
        do_frame("bad_stop_33", 8'h33, 0, 1, 0);
        do_frame("good_33", 8'h33, 0, 0, 0);

        do_frame("ext_before_tmo", 8'hE0, 0, 0, 0);
        send_frame(8'hA5, 0, 0, 4, 0);
        wait_cyc(TMO + 20);
        model_frame(8'hA5, 1'b1, 1'b0);
        verify("timeout_partial");
        do_frame("after_tmo_5a", 8'h5A, 0, 0, 0);

        do_frame("glitch_1c", 8'h1C, 0, 0, 1);

        do_frame("ext_before_rst", 8'hE0, 0, 0, 0);
        do_frame("right_make", 8'h74, 0, 0, 0);
        do_frame("ext_pending", 8'hE0, 0, 0, 0);
        send_frame(8'h4D, 0, 0, 5, 0);
        rst_n = 1'b0;
        wait_cyc(5);
        check_all_zero("midrst.during");
        rst_n = 1'b1;
        wait_cyc(3);
        check_all_zero("midrst.after");
        m_brk = 1'b0; m_ext = 1'b0; m_keys = 4'b0; last_exp = '0;
        verify("midrst.idle");
        do_frame("after_rst_1c", 8'h1C, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      b = 8'hF0;
            else if (r == 1) b = 8'hE0;
            else if (r < 4)  b = arrows[$urandom_range(0, 3)];
            else             b = 8'($urandom);
            do_frame("random", b, ($urandom_range(0, 5) == 0), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
